// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
// Funct3 access codes and the responder FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and extension for loads.
// DMEM_MISALIGN_CHECK_EN flags misaligned halfword/word accesses instead of aligning them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offs,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        bad_f3,
  output logic        misaligned
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [1:0]  eo;
  logic [31:0] sh;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_w = (funct3 == F3_W);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign eo         = offs;
  assign misaligned = (is_h && offs[0]) ||
                      (is_w && (offs != 2'b00));
`else
  // Without the check, low address bits are dropped to the access size.
  assign eo         = is_w ? 2'b00 :
                      is_h ? {offs[1], 1'b0} : offs;
  assign misaligned = 1'b0;
`endif

  assign sh = rd_word >> {eo, 3'b000};

  always_comb begin
    be      = 4'b0000;
    wr_word = '0;
    bad_f3  = 1'b0;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << eo;
        wr_word = {4{wr_data[7:0]}};
      end
      is_h: begin
        be      = 4'b0011 << eo;
        wr_word = {2{wr_data[15:0]}};
      end
      is_w: begin
        be      = 4'b1111;
        wr_word = wr_data;
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      funct3 == F3_B:  ld_data = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_BU: ld_data = {24'd0, sh[7:0]};
      funct3 == F3_H:  ld_data = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_HU: ld_data = {16'd0, sh[15:0]};
      funct3 == F3_W:  ld_data = sh;
      default:         ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with Ready/Err pulses.
// Optional DMEM_MISALIGN_CHECK_EN turns misaligned accesses into errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Ready,
  output logic              Err
);

  localparam int         IW     = $clog2(DEPTH);
  localparam int         AW     = IW + 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         LAT1   = (LATENCY == 1);

  dmem_state_t state_q;
  dmem_state_t state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic [AW-1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wd_q;
  logic          wr_q;
  logic          both_q;

  logic          idle;
  logic          start;
  logic          capture;
  logic          enter_done;
  logic [AW-1:0] a_addr;
  logic [2:0]    a_f3;
  logic [31:0]   a_wd;
  logic          a_wr;
  logic          a_both;
  logic [IW-1:0] idx;

  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] ld_data;
  logic [31:0] bmask;
  logic [3:0]  be;
  logic        bad_f3;
  logic        misaligned;
  logic        illegal;
  logic        commit;
  logic        unused_addr;

  logic [31:0] mem [DEPTH];

  assign unused_addr = ^Addr[ADDR_W-1:AW];

  assign idle  = (state_q == IDLE);
  assign start = MemRead | MemWrite;

  // In IDLE the live inputs drive the datapath so LATENCY=1 can
  // commit on the same edge that captures the request.
  assign a_addr = idle ? Addr[AW-1:0]         : addr_q;
  assign a_f3   = idle ? Funct3               : f3_q;
  assign a_wd   = idle ? WrData               : wd_q;
  assign a_wr   = idle ? MemWrite             : wr_q;
  assign a_both = idle ? (MemRead & MemWrite) : both_q;

  assign idx     = a_addr[AW-1:2];
  assign rd_word = mem[idx];

  dmem_lane_align u_align (
    .funct3     (a_f3),
    .offs       (a_addr[1:0]),
    .wr_data    (a_wd),
    .rd_word    (rd_word),
    .be         (be),
    .wr_word    (wr_word),
    .ld_data    (ld_data),
    .bad_f3     (bad_f3),
    .misaligned (misaligned)
  );

  assign illegal = a_both | bad_f3 | misaligned;
  assign commit  = enter_done & a_wr & ~illegal;
  assign bmask   = {{8{be[3]}}, {8{be[2]}},
                    {8{be[1]}}, {8{be[0]}}};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (LAT1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      wd_q    <= 32'd0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      RdData  <= 32'd0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Ready   <= (state_q == DONE);
      Err     <= (state_q == DONE) && illegal;
      if (capture) begin
        addr_q <= Addr[AW-1:0];
        f3_q   <= Funct3;
        wd_q   <= WrData;
        wr_q   <= MemWrite;
        both_q <= MemRead & MemWrite;
      end
      if (enter_done && !a_wr && !illegal) begin
        RdData <= ld_data;
      end
    end
  end

  // Storage is not reset; an in-flight store is dropped by reset.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      mem[idx] <= (rd_word & ~bmask) | (wr_word & bmask);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks against a byte-array model.
// Build with DMEM_MISALIGN_CHECK_EN defined to exercise the misalignment errors.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WrData = 32'd0;
  logic [31:0] RdData;
  logic        Ready;
  logic        Err;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mm [1024];
  logic [31:0] exp_rd = 32'd0;

  dmem_responder #(
    .DEPTH   (256),
    .ADDR_W  (32),
    .LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .Ready    (Ready),
    .Err      (Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Little-endian byte memory; memory index is address mod 1024 bytes.
  task automatic model_access(input logic r, input logic w,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic e);
    int size;
    int ea;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ea = int'(a[9:0]);
    e = (r && w) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (ea % size != 0) e = 1'b1;
`else
    ea = ea - (ea % size);
`endif
    if (e) return;
    if (w) begin
      for (int i = 0; i < size; i++) mm[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mm[ea + i];
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
      exp_rd = v;
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string tag);
    int n;
    logic e;
    MemRead = r;
    MemWrite = w;
    Funct3 = f3;
    Addr = a;
    WrData = wd;
    model_access(r, w, f3, a, wd, e);
    @(posedge clk); #1;
    Addr = $urandom;
    WrData = $urandom;
    Funct3 = 3'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!Ready && n < 20);
    chk({tag, ".lat"}, n, LAT);
    chk({tag, ".rdy"}, {31'd0, Ready}, 32'd1);
    chk({tag, ".err"}, {31'd0, Err}, {31'd0, e});
    chk({tag, ".rd"}, RdData, exp_rd);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {30'd0, Ready, Err}, 32'd0);
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] bad_f3 [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    int cyc;
    int last;
    int pulses;
    int sel;
    logic e;
    logic [2:0] f3;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.rdy", {31'd0, Ready}, 32'd0);
    chk("rst.err", {31'd0, Err}, 32'd0);
    chk("rst.rd", RdData, 32'd0);

    for (int k = 0; k < 32; k++)
      access(1'b0, 1'b1, 3'd2, 32'(4*k), $urandom, "fill");

    access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "t1.sw");
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "t1.lw");
    chk("t1.val", RdData, 32'hDEADBEEF);

    access(1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344, "t2.sw");
    access(1'b0, 1'b1, 3'd0, 32'h13, 32'h00000080, "t2.sb");
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "t2.lw");
    chk("t2.lwv", RdData, 32'h80223344);
    access(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, "t2.lb");
    chk("t2.lbv", RdData, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, "t2.lbu");
    chk("t2.lbuv", RdData, 32'h00000080);

    access(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, "t3.lh");
    chk("t3.lhv", RdData, 32'hFFFF8022);
    access(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, "t3.lhu");
    chk("t3.lhuv", RdData, 32'h00008022);

    access(1'b1, 1'b1, 3'd2, 32'h10, 32'h55555555, "t4.both");
    chk("t4.rdkeep", RdData, 32'h00008022);
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "t4.lw");
    chk("t4.memkeep", RdData, 32'h80223344);

    access(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, "t5.pre");
    access(1'b1, 1'b0, 3'd2, 32'h11, 32'h0, "t5.lw");
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("t5.val", RdData, 32'h00008022);
`else
    chk("t5.val", RdData, 32'h80223344);
`endif

    access(1'b0, 1'b1, 3'd2, 32'h20, 32'hA5A50001, "t6.init");
    MemWrite = 1'b1;
    Funct3 = 3'd2;
    Addr = 32'h20;
    WrData = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b1;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 32'd0;
    chk("t6.rd0", RdData, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t6.nordy", {31'd0, Ready}, 32'd0);
      @(posedge clk); #1;
    end
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, "t6.lw");
    chk("t6.old", RdData, 32'hA5A50001);

    MemWrite = 1'b1;
    Funct3 = 3'd2;
    Addr = 32'h24;
    WrData = 32'hCAFEF00D;
    model_access(1'b0, 1'b1, 3'd2, 32'h24, 32'hCAFEF00D, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 32'd0;
    chk("t6.done_rdy", {31'd0, Ready}, 32'd0);
    access(1'b1, 1'b0, 3'd2, 32'h24, 32'h0, "t6.lw2");
    chk("t6.kept", RdData, 32'hCAFEF00D);

    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "b2b.pre");
    MemRead = 1'b1;
    Funct3 = 3'd2;
    Addr = 32'h10;
    cyc = 0;
    last = -1;
    pulses = 0;
    while (pulses < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (Ready) begin
        if (last >= 0) chk("b2b.gap", 32'(cyc - last), 32'(LAT + 1));
        chk("b2b.rd", RdData, 32'h80223344);
        last = cyc;
        pulses++;
        if (pulses == 3) MemRead = 1'b0;
      end
    end
    chk("b2b.count", 32'(pulses), 32'd3);
    @(posedge clk); #1;
    chk("b2b.idle", {31'd0, Ready}, 32'd0);

    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 127));
      if (sel == 0) begin
        access(1'b1, 1'b1, 3'd2, a, $urandom, "rnd.both");
      end else if (sel == 1) begin
        f3 = bad_f3[$urandom_range(0, 2)];
        access(1'b1, 1'b0, f3, a, $urandom, "rnd.badf3");
      end else if (sel <= 4) begin
        f3 = 3'($urandom_range(0, 2));
        access(1'b0, 1'b1, f3, a, $urandom, "rnd.st");
      end else begin
        f3 = ld_f3[$urandom_range(0, 4)];
        access(1'b1, 1'b0, f3, a, 32'h0, "rnd.ld");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
